// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts an accepted pattern out MSB-first with
// programmable repeats and gaps, and counts the three-ones events it emits.
module seq_pattern_tx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pat_valid,
  output logic                    pat_ready,
  input  logic [DATA_W-1:0]       pat_data,
  input  logic [$clog2(DATA_W):0] pat_len,
  input  logic [CNT_W-1:0]        rep_cnt,
  input  logic [3:0]              gap_len,
  input  logic                    abort,
  output logic                    tx_d,
  output logic                    tx_en,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        run3_cnt
);

  localparam int LEN_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [3:0]        gap_q, gap_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [1:0]        hist_q, hist_d;
  logic [CNT_W-1:0]  run3_q, run3_d;
  logic              tx_d_q, tx_d_d;
  logic              tx_en_q, tx_en_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_clamped;
  logic              cur_bit;

  assign pat_ready   = (state_q == IDLE) && !abort;
  assign busy        = (state_q != IDLE);
  assign tx_d        = tx_d_q;
  assign tx_en       = tx_en_q;
  assign done        = done_q;
  assign run3_cnt    = run3_q;
  assign cur_bit     = shift_q[DATA_W-1];
  assign len_clamped = ((pat_len == '0) || (pat_len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : pat_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      hist_q  <= '0;
      run3_q  <= '0;
      tx_d_q  <= 1'b0;
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      hist_q  <= hist_d;
      run3_q  <= run3_d;
      tx_d_q  <= tx_d_d;
      tx_en_q <= tx_en_d;
      done_q  <= done_d;
    end
  end

  // bit_q == 0 while in SEND marks the completion cycle that raises done.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pat_d   = pat_q;
    len_d   = len_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    hist_d  = 2'b00;
    run3_d  = run3_q;
    tx_d_d  = 1'b0;
    tx_en_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pat_valid && pat_ready) begin
          shift_d = pat_data;
          pat_d   = pat_data;
          len_d   = len_clamped;
          bit_d   = len_clamped;
          rep_d   = rep_cnt;
          gap_d   = gap_len;
          run3_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (bit_q != '0) begin
          tx_en_d = 1'b1;
          tx_d_d  = cur_bit;
          hist_d  = {hist_q[0], cur_bit};
          if (cur_bit && (hist_q == 2'b11) && (run3_q != '1))
            run3_d = run3_q + 1'b1;
          shift_d = shift_q << 1;
          bit_d   = bit_q - 1'b1;
          if ((bit_q == LEN_W'(1)) && (rep_q != '0)) begin
            if (gap_q != 4'd0) begin
              state_d = GAP;
              gcnt_d  = gap_q;
            end else begin
              shift_d = pat_q;
              bit_d   = len_q;
              rep_d   = rep_q - 1'b1;
            end
          end
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      GAP: begin
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == 4'd1) begin
          shift_d = pat_q;
          bit_d   = len_q;
          rep_d   = rep_q - 1'b1;
          state_d = SEND;
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort wins over everything but keeps the event count for inspection.
    if (abort) begin
      state_d = IDLE;
      tx_en_d = 1'b0;
      tx_d_d  = 1'b0;
      done_d  = 1'b0;
      hist_d  = 2'b00;
      run3_d  = run3_q;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a cycle-stream model built from the
// burst rules, compared every cycle, plus directed literal checks.
module tb_seq_pattern_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pat_valid = 1'b0;
  logic        pat_ready;
  logic [15:0] pat_data = '0;
  logic [4:0]  pat_len = '0;
  logic [3:0]  rep_cnt = '0;
  logic [3:0]  gap_len = '0;
  logic        abort = 1'b0;
  logic        tx_d, tx_en, busy, done;
  logic [3:0]  run3_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit live = 1'b0;

  // Model: queue of {en, d, done} for upcoming edges; empty means IDLE.
  logic [2:0] stream[$];
  logic [2:0] cur;
  int         run_len = 0;
  int         exp_run3 = 0;
  logic       exp_en = 1'b0, exp_d = 1'b0, exp_done = 1'b0;

  seq_pattern_tx #(.DATA_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len),
    .abort(abort), .tx_d(tx_d), .tx_en(tx_en), .busy(busy), .done(done),
    .run3_cnt(run3_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic build_stream(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r, input logic [3:0] g);
    int n;
    n = ((l == 5'd0) || (l > 5'd16)) ? 16 : int'(l);
    for (int rr = 0; rr <= int'(r); rr++) begin
      for (int i = 0; i < n; i++) stream.push_back({1'b1, d[15-i], 1'b0});
      if (rr < int'(r))
        for (int k = 0; k < int'(g); k++) stream.push_back(3'b000);
    end
    stream.push_back(3'b001);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        stream.delete();
        run_len  = 0;
        exp_run3 = 0;
        exp_en   = 1'b0;
        exp_d    = 1'b0;
        exp_done = 1'b0;
      end else begin
        cur = 3'b000;
        if (abort) stream.delete();
        else if (stream.size() != 0) cur = stream.pop_front();
        else if (pat_valid) begin
          build_stream(pat_data, pat_len, rep_cnt, gap_len);
          exp_run3 = 0;
        end
        exp_en   = cur[2];
        exp_d    = cur[1];
        exp_done = cur[0];
        if (cur[2] && cur[1]) begin
          run_len++;
          if (run_len >= 3 && exp_run3 < 15) exp_run3++;
        end else begin
          run_len = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && live) begin
        checkOutput("tx_en", 32'(tx_en), 32'(exp_en));
        checkOutput("tx_d", 32'(tx_d), 32'(exp_d));
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("run3_cnt", 32'(run3_cnt), 32'(exp_run3));
        checkOutput("busy", 32'(busy), 32'(stream.size() != 0));
        checkOutput("pat_ready", 32'(pat_ready), 32'((stream.size() == 0) && !abort));
      end
    end
  end

  // Presents a request so it is accepted on the next rising edge, then scrambles
  // the sampled inputs to show they are ignored after accept.
  task automatic applyStimulus(input logic [15:0] d, input logic [4:0] l, input logic [3:0] r, input logic [3:0] g);
    pat_data  = d;
    pat_len   = l;
    rep_cnt   = r;
    gap_len   = g;
    pat_valid = 1'b1;
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
    pat_data  = 16'($urandom);
    pat_len   = 5'($urandom);
    rep_cnt   = 4'($urandom);
    gap_len   = 4'($urandom);
  endtask

  task automatic collect(input int budget, output int done_at, output int first_at,
                         output int nbits, output logic [63:0] bits, output logic [63:0] en_trace);
    done_at = -1; first_at = -1; nbits = 0; bits = '0; en_trace = '0;
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      en_trace[j] = tx_en;
      if (tx_en) begin
        if (first_at < 0) first_at = j;
        bits = {bits[62:0], tx_d};
        nbits++;
      end
      if (done) begin
        done_at = j;
        break;
      end
    end
    if (done_at < 0) checkOutput("done_within_budget", 32'(done), 32'd1);
  endtask

  int done_at, first_at, nbits;
  logic [63:0] bits, en_trace;

  initial begin
    #1;
    checkOutput("reset_tx_en", 32'(tx_en), 0);
    checkOutput("reset_tx_d", 32'(tx_d), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_run3", 32'(run3_cnt), 0);
    checkOutput("reset_ready", 32'(pat_ready), 1);
    #21;
    rst_n = 1'b1;
    live  = 1'b1;

    @(negedge clk);
    applyStimulus(16'hE000, 5'd3, 4'd0, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("basic_first", 32'(first_at), 1);
    checkOutput("basic_done", 32'(done_at), 4);
    checkOutput("basic_nbits", 32'(nbits), 3);
    checkOutput("basic_bits", bits[31:0], 32'h7);
    checkOutput("basic_run3", 32'(run3_cnt), 1);
    checkOutput("basic_ready", 32'(pat_ready), 1);

    @(negedge clk);
    applyStimulus(16'hF800, 5'd5, 4'd1, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("b2b_done", 32'(done_at), 11);
    checkOutput("b2b_en", 32'(en_trace[10:1]), 32'h3FF);
    checkOutput("b2b_bits", bits[31:0], 32'h3FF);
    checkOutput("b2b_run3", 32'(run3_cnt), 8);

    @(negedge clk);
    applyStimulus(16'hF800, 5'd5, 4'd1, 4'd2);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("gap_done", 32'(done_at), 13);
    checkOutput("gap_en_first", 32'(en_trace[5:1]), 32'h1F);
    checkOutput("gap_en_low", 32'(en_trace[7:6]), 0);
    checkOutput("gap_en_second", 32'(en_trace[12:8]), 32'h1F);
    checkOutput("gap_run3", 32'(run3_cnt), 6);

    @(negedge clk);
    applyStimulus(16'hA5A5, 5'd0, 4'd0, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("clamp0_nbits", 32'(nbits), 16);
    checkOutput("clamp0_bits", bits[31:0], 32'hA5A5);
    checkOutput("clamp0_done", 32'(done_at), 17);
    checkOutput("clamp0_run3", 32'(run3_cnt), 0);

    @(negedge clk);
    applyStimulus(16'h8001, 5'd31, 4'd0, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("clamp31_nbits", 32'(nbits), 16);
    checkOutput("clamp31_bits", bits[31:0], 32'h8001);

    @(negedge clk);
    applyStimulus(16'hFFFF, 5'd16, 4'd1, 4'd0);
    collect(60, done_at, first_at, nbits, bits, en_trace);
    checkOutput("sat_nbits", 32'(nbits), 32);
    checkOutput("sat_done", 32'(done_at), 33);
    checkOutput("sat_run3", 32'(run3_cnt), 15);

    @(negedge clk);
    applyStimulus(16'hFF00, 5'd16, 4'd0, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx_en", 32'(tx_en), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_ready", 32'(pat_ready), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_run3", 32'(run3_cnt), 2);
    repeat (20) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 0);
    end

    @(negedge clk);
    #1;
    abort     = 1'b1;
    pat_valid = 1'b1;
    pat_data  = 16'hFFFF;
    pat_len   = 5'd4;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    pat_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_block_busy", 32'(busy), 0);
    checkOutput("abort_block_run3", 32'(run3_cnt), 2);
    @(negedge clk);
    checkOutput("abort_block_en", 32'(tx_en), 0);

    @(negedge clk);
    applyStimulus(16'hF800, 5'd5, 4'd1, 4'd4);
    repeat (7) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    checkOutput("pre_reset_run3", 32'(run3_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx_en", 32'(tx_en), 0);
    checkOutput("midreset_tx_d", 32'(tx_d), 0);
    checkOutput("midreset_done", 32'(done), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_run3", 32'(run3_cnt), 0);
    checkOutput("midreset_ready", 32'(pat_ready), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    applyStimulus(16'hE000, 5'd3, 4'd0, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("chain_a_done", 32'(done_at), 4);
    applyStimulus(16'hA000, 5'd3, 4'd0, 4'd0);
    collect(40, done_at, first_at, nbits, bits, en_trace);
    checkOutput("chain_b_first", 32'(first_at), 1);
    checkOutput("chain_b_bits", bits[31:0], 32'h5);
    checkOutput("chain_b_done", 32'(done_at), 4);
    checkOutput("chain_b_run3", 32'(run3_cnt), 0);

    repeat (3000) begin
      @(posedge clk);
      #1;
      pat_valid = ($urandom_range(0, 3) == 0);
      pat_data  = 16'($urandom);
      pat_len   = 5'($urandom_range(0, 31));
      rep_cnt   = 4'($urandom_range(0, 2));
      gap_len   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      abort     = ($urandom_range(0, 39) == 0);
    end
    pat_valid = 1'b0;
    abort     = 1'b0;
    repeat (120) @(negedge clk);
    checkOutput("final_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
